// File: rtl/pixel_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_loader
// Description : Assembles a host byte stream into RGB888 or 8-bit gray pixels,
//               strobes each pixel into the gray/Sobel datapath and pulses
//               finish once a full frame of IMG_WIDTH*IMG_HEIGHT pixels is out.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_stream_loader #(
  parameter int PIXEL_BITS = 24,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int CNT_BITS   = $clog2(IMG_WIDTH*IMG_HEIGHT+1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  frame_start_i,
  input  logic [1:0]            select_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic [PIXEL_BITS-1:0] pixel_o,
  output logic                  start_o,
  output logic                  finish_o,
  output logic [1:0]            select_o,
  output logic                  busy_o
);

  localparam logic [CNT_BITS-1:0] PIX_TOTAL = CNT_BITS'(IMG_WIDTH*IMG_HEIGHT);
  localparam logic [1:0]          SEL_GRAY  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [1:0]            select_q, select_d;
  logic [7:0]            byte0_q, byte0_d;
  logic [7:0]            byte1_q, byte1_d;
  logic [PIXEL_BITS-1:0] pixel_q, pixel_d;
  logic                  start_q, start_d;
  logic                  ready;
  logic                  xfer;

  // Ready only while loading and the frame is not yet complete; once the last
  // pixel is counted (its start cycle) ready drops so no extra bytes enter.
  assign ready        = (state_q == ST_LOAD) && (cnt_q != PIX_TOTAL);
  assign xfer         = ready && byte_valid_i;
  assign byte_ready_o = ready;
  assign pixel_o      = pixel_q;
  assign start_o      = start_q;
  assign finish_o     = (state_q == ST_FINISH);
  assign select_o     = select_q;
  assign busy_o       = (state_q != ST_IDLE);

  // Next-state, byte assembly and pixel counting.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    select_d = select_q;
    byte0_d  = byte0_q;
    byte1_d  = byte1_q;
    pixel_d  = pixel_q;
    start_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start_i) begin
          state_d  = ST_LOAD;
          select_d = select_i;
          idx_d    = 2'd0;
          cnt_d    = '0;
        end
      end
      ST_LOAD: begin
        if (cnt_q == PIX_TOTAL) begin
          // Last pixel's strobe is on the bus this cycle; finish follows next.
          state_d = ST_FINISH;
        end else if (xfer) begin
          if (select_q == SEL_GRAY) begin
            pixel_d = PIXEL_BITS'(byte_i);
            start_d = 1'b1;
            cnt_d   = cnt_q + CNT_BITS'(1);
            idx_d   = 2'd0;
          end else begin
            case (idx_q)
              2'd0: begin
                byte0_d = byte_i;
                idx_d   = 2'd1;
              end
              2'd1: begin
                byte1_d = byte_i;
                idx_d   = 2'd2;
              end
              default: begin
                pixel_d = PIXEL_BITS'({byte0_q, byte1_q, byte_i});
                start_d = 1'b1;
                cnt_d   = cnt_q + CNT_BITS'(1);
                idx_d   = 2'd0;
              end
            endcase
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      select_q <= 2'b00;
      byte0_q  <= 8'h00;
      byte1_q  <= 8'h00;
      pixel_q  <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      select_q <= select_d;
      byte0_q  <= byte0_d;
      byte1_q  <= byte1_d;
      pixel_q  <= pixel_d;
      start_q  <= start_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_stream_loader
// Description : Self-checking bench for pixel_stream_loader (2x2 frame) with a
//               byte-queue reference model plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_stream_loader;

  localparam int TOTAL = 4;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        frame_start_i = 1'b0;
  logic [1:0]  select_i = 2'b00;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic [23:0] pixel_o;
  logic        start_o;
  logic        finish_o;
  logic [1:0]  select_o;
  logic        busy_o;

  pixel_stream_loader #(
    .PIXEL_BITS(24),
    .IMG_WIDTH (2),
    .IMG_HEIGHT(2)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .frame_start_i(frame_start_i),
    .select_i     (select_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .pixel_o      (pixel_o),
    .start_o      (start_o),
    .finish_o     (finish_o),
    .select_o     (select_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: bytes of the current pixel queue up until the mode's
  // bytes-per-pixel is reached; frames end after TOTAL pixels.
  bit          m_active = 0;
  bit          m_fin = 0;
  logic [1:0]  m_sel = 2'b00;
  int          m_pixels = 0;
  logic [7:0]  m_buf[$];
  logic [23:0] e_pixel = 24'h0;
  logic        e_start = 1'b0;
  logic        e_finish = 1'b0;
  logic [1:0]  e_sel = 2'b00;
  logic        e_busy = 1'b0;
  logic        e_ready = 1'b0;

  // Observed output log for the literal checks.
  logic [23:0] dut_pix[$];
  int          fin_cnt = 0;
  int          start_cnt = 0;
  int          first_start = 0;
  int          last_start = 0;
  int          last_fin = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int bpp;
    cyc++;
    if (reset_i) begin
      m_active = 0;
      m_fin    = 0;
      m_sel    = 2'b00;
      m_pixels = 0;
      m_buf.delete();
      e_pixel  = 24'h0;
      e_start  = 1'b0;
      e_finish = 1'b0;
      e_sel    = 2'b00;
    end else begin
      e_start = 1'b0;
      bpp = (m_sel == 2'b01) ? 1 : 3;
      if (m_fin) begin
        m_fin = 0;
      end else if (m_active) begin
        if (m_pixels == TOTAL) begin
          m_active = 0;
          m_fin    = 1;
        end else if (byte_valid_i) begin
          m_buf.push_back(byte_i);
          if (m_buf.size() == bpp) begin
            e_pixel = (bpp == 1) ? {16'h0000, m_buf[0]} : {m_buf[0], m_buf[1], m_buf[2]};
            e_start = 1'b1;
            m_pixels++;
            m_buf.delete();
          end
        end
      end else if (frame_start_i) begin
        m_active = 1;
        m_sel    = select_i;
        m_pixels = 0;
        m_buf.delete();
      end
      e_finish = m_fin;
      e_sel    = m_sel;
    end
    e_busy  = m_active || m_fin;
    e_ready = m_active && (m_pixels < TOTAL);
  end

  // Every-cycle comparison against the model, plus output logging.
  always @(negedge clk) begin
    chk("pixel_o", {8'h0, pixel_o}, {8'h0, e_pixel});
    chk("start_o", {31'h0, start_o}, {31'h0, e_start});
    chk("finish_o", {31'h0, finish_o}, {31'h0, e_finish});
    chk("select_o", {30'h0, select_o}, {30'h0, e_sel});
    chk("busy_o", {31'h0, busy_o}, {31'h0, e_busy});
    chk("byte_ready_o", {31'h0, byte_ready_o}, {31'h0, e_ready});
    if (start_o === 1'b1) begin
      if (dut_pix.size() == 0) first_start = cyc;
      dut_pix.push_back(pixel_o);
      start_cnt++;
      last_start = cyc;
    end
    if (finish_o === 1'b1) begin
      fin_cnt++;
      last_fin = cyc;
    end
  end

  task automatic drv(input logic rst, input logic fs, input logic [1:0] sel,
                     input logic v, input logic [7:0] b);
    reset_i       = rst;
    frame_start_i = fs;
    select_i      = sel;
    byte_valid_i  = v;
    byte_i        = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
  endtask

  task automatic clr_logs();
    dut_pix.delete();
    fin_cnt   = 0;
    start_cnt = 0;
  endtask

  task automatic chk_frame(input string nm, input logic [23:0] p0, input logic [23:0] p1,
                           input logic [23:0] p2, input logic [23:0] p3);
    logic [23:0] exp_p[4];
    exp_p[0] = p0; exp_p[1] = p1; exp_p[2] = p2; exp_p[3] = p3;
    chk({nm, "_count"}, dut_pix.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < dut_pix.size()) chk({nm, "_pix"}, {8'h0, dut_pix[i]}, {8'h0, exp_p[i]});
    end
    chk({nm, "_finish_cnt"}, fin_cnt, 1);
    chk({nm, "_finish_gap"}, last_fin - last_start, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    idle(1);

    // RGB, 12 back-to-back bytes.
    clr_logs();
    drv(0, 1, 2'b00, 0, 8'h00);
    for (int i = 0; i < 12; i++) drv(0, 0, 2'b00, 1, 8'h11 + 8'(i));
    idle(5);
    chk_frame("rgb", 24'h111213, 24'h141516, 24'h171819, 24'h1A1B1C);

    // Gray, one pixel per cycle.
    clr_logs();
    drv(0, 1, 2'b01, 0, 8'h00);
    for (int i = 0; i < 4; i++) drv(0, 0, 2'b00, 1, 8'hA0 + 8'(i));
    idle(5);
    chk_frame("gray", 24'h0000A0, 24'h0000A1, 24'h0000A2, 24'h0000A3);
    chk("gray_consecutive", last_start - first_start, 3);

    // RGB with a valid byte only every third cycle.
    clr_logs();
    drv(0, 1, 2'b00, 0, 8'h00);
    for (int i = 0; i < 12; i++) begin
      drv(0, 0, 2'b00, 1, 8'h11 + 8'(i));
      drv(0, 0, 2'b00, 0, 8'hEE);
      drv(0, 0, 2'b00, 0, 8'hEE);
    end
    idle(5);
    chk_frame("gaps", 24'h111213, 24'h141516, 24'h171819, 24'h1A1B1C);
    chk("gaps_starts", start_cnt, 4);

    // Reset after 5 bytes, then a fresh frame.
    clr_logs();
    drv(0, 1, 2'b00, 0, 8'h00);
    for (int i = 0; i < 5; i++) drv(0, 0, 2'b00, 1, 8'h11 + 8'(i));
    drv(1, 1, 2'b01, 1, 8'h99);
    idle(4);
    chk("abort_pixels", dut_pix.size(), 1);
    chk("abort_finish", fin_cnt, 0);
    clr_logs();
    drv(0, 1, 2'b00, 0, 8'h00);
    for (int i = 0; i < 12; i++) drv(0, 0, 2'b00, 1, 8'h30 + 8'(i));
    idle(5);
    chk_frame("after_rst", 24'h303132, 24'h333435, 24'h363738, 24'h393A3B);

    // Mid-frame frame_start and select changes are ignored.
    clr_logs();
    drv(0, 1, 2'b00, 0, 8'h00);
    for (int i = 0; i < 12; i++) drv(0, 1'(i % 2), 2'($urandom_range(3)), 1, 8'h40 + 8'(i));
    drv(0, 1, 2'b10, 0, 8'h00);
    drv(0, 1, 2'b10, 0, 8'h00);
    idle(4);
    chk_frame("midsel", 24'h404142, 24'h434445, 24'h464748, 24'h494A4B);

    // Two surplus bytes after the last pixel are dropped.
    clr_logs();
    drv(0, 1, 2'b00, 0, 8'h00);
    for (int i = 0; i < 14; i++) drv(0, 0, 2'b00, 1, 8'h50 + 8'(i));
    idle(5);
    chk_frame("extra", 24'h505152, 24'h535455, 24'h565758, 24'h595A5B);
    chk("extra_starts", start_cnt, 4);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      drv(1'($urandom_range(199) == 0), 1'($urandom_range(19) == 0),
          2'($urandom_range(3)), 1'($urandom_range(9) < 7), 8'($urandom));
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
